// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the signals between two requesters, the arbiter and one RAM port.
//   m0_* / m1_*  : request, access type (0 = write, 1 = read), word address,
//                  write data, ack pulse, out-of-range flag and read data.
//   ram_*        : address, access type and write data towards the RAM, and
//                  combinational read data coming back from it.
// Modports:
//   slave  - the arbiter: takes requests and RAM read data, drives the rest.
//   master - the surroundings (requesters plus RAM): the mirror image.
interface ram_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic        m0_w_r;
  logic        m1_w_r;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wr_data;
  logic [31:0] m1_wr_data;
  logic        m0_ack;
  logic        m1_ack;
  logic        m0_err;
  logic        m1_err;
  logic [31:0] m0_rd_data;
  logic [31:0] m1_rd_data;
  logic [31:0] ram_addr;
  logic        ram_w_r;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;

  modport slave (
    input  m0_req, m1_req, m0_w_r, m1_w_r, m0_addr, m1_addr,
    input  m0_wr_data, m1_wr_data, ram_rd_data,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rd_data, m1_rd_data,
    output ram_addr, ram_w_r, ram_wr_data
  );

  modport master (
    output m0_req, m1_req, m0_w_r, m1_w_r, m0_addr, m1_addr,
    output m0_wr_data, m1_wr_data, ram_rd_data,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rd_data, m1_rd_data,
    input  ram_addr, ram_w_r, ram_wr_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between two requesters. Every access takes a
// fixed three-cycle walk IDLE -> ACCESS -> DONE: the request is latched in
// IDLE, driven onto the RAM for exactly one cycle in ACCESS (read data is
// registered at the end of it), and acknowledged with a one-cycle pulse in
// DONE. Addresses above 99 are not forwarded to the RAM and complete with
// err = 1 and rd_data = 0.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - ram_arbiter_if.slave (requester and RAM signals)
// Configuration:
//   ARB_ROUND_ROBIN_EN defined   - ties go to the requester that was not
//                                  granted last (last_grant resets to 1, so
//                                  requester 0 wins the first tie).
//   ARB_ROUND_ROBIN_EN undefined - fixed priority, requester 0 wins ties.
module ram_arbiter (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  ACCESS   = 2'd1;
  localparam logic [1:0]  DONE     = 2'd2;
  localparam logic [31:0] ADDR_MAX = 32'h0000_0063;

  logic [1:0]  state_reg;
  logic        id_reg;
  logic        w_r_reg;
  logic        in_range_reg;
  logic [31:0] addr_reg;
  logic [31:0] wr_data_reg;

  logic [1:0]  ack_reg;
  logic [1:0]  err_reg;
  logic [31:0] rd_data_reg [2];

  logic        any_req;
  logic        grant_id;
  logic        sel_w_r;
  logic [31:0] sel_addr;
  logic [31:0] sel_wr_data;
  logic        access_ok;
  logic [1:0]  served;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_reg;
`endif

  assign any_req = bus.m0_req | bus.m1_req;

  // A lone request always wins; only a tie looks at the policy.
  always_comb begin
    grant_id = ~bus.m0_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.m0_req && bus.m1_req) begin
      grant_id = ~last_grant_reg;
    end
`endif
  end

  assign sel_w_r     = grant_id ? bus.m1_w_r     : bus.m0_w_r;
  assign sel_addr    = grant_id ? bus.m1_addr    : bus.m0_addr;
  assign sel_wr_data = grant_id ? bus.m1_wr_data : bus.m0_wr_data;

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (state_reg == IDLE && any_req) begin
      last_grant_reg <= grant_id;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      id_reg       <= 1'b0;
      w_r_reg      <= 1'b1;
      in_range_reg <= 1'b0;
      addr_reg     <= 32'h0;
      wr_data_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            id_reg       <= grant_id;
            w_r_reg      <= sel_w_r;
            in_range_reg <= (sel_addr <= ADDR_MAX);
            addr_reg     <= sel_addr;
            wr_data_reg  <= sel_wr_data;
            state_reg    <= ACCESS;
          end
        end
        ACCESS:  state_reg <= DONE;
        DONE:    state_reg <= IDLE;  // requests are not looked at here
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The RAM only sees a real access during ACCESS and only for a valid
  // address; everywhere else it sees a harmless read of word 0. Because this
  // is decoded from the state register, a reset during ACCESS drops the RAM
  // back to read in the very next cycle.
  assign access_ok       = (state_reg == ACCESS) && in_range_reg;
  assign bus.ram_addr    = access_ok ? addr_reg    : 32'h0;
  assign bus.ram_w_r     = access_ok ? w_r_reg     : 1'b1;
  assign bus.ram_wr_data = access_ok ? wr_data_reg : 32'h0;

  // served[i]: requester i owns the access that ends at this clock edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_served
    assign served[gi] = (state_reg == ACCESS) && (id_reg == 1'(gi));
  end

  // Ack and err are registered at the end of ACCESS so they line up with
  // DONE; they drop again after one cycle since ACCESS never lasts longer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_reg <= 2'b00;
      err_reg <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rd_data_reg[i] <= 32'h0;
      end
    end else begin
      ack_reg <= served;
      err_reg <= served & {2{~in_range_reg}};
      for (int i = 0; i < 2; i++) begin
        if (served[i]) begin
          if (!in_range_reg) begin
            rd_data_reg[i] <= 32'h0;
          end else if (w_r_reg) begin
            rd_data_reg[i] <= bus.ram_rd_data;
          end
        end
      end
    end
  end

  assign bus.m0_ack     = ack_reg[0];
  assign bus.m1_ack     = ack_reg[1];
  assign bus.m0_err     = err_reg[0];
  assign bus.m1_err     = err_reg[1];
  assign bus.m0_rd_data = rd_data_reg[0];
  assign bus.m1_rd_data = rd_data_reg[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Drives ram_arbiter through its interface with a small 100-word RAM model,
// checking every cycle of each transaction against a reference model of the
// arbitration, memory and response rules.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM attached to the arbiter: combinational read, write on the edge.
  logic [31:0] ram_mem [100];
  assign bus.ram_rd_data = (bus.ram_addr < 32'd100) ? ram_mem[bus.ram_addr[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 100; i++) ram_mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (!bus.ram_w_r && bus.ram_addr < 32'd100) begin
      ram_mem[bus.ram_addr[6:0]] <= bus.ram_wr_data;
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] ref_mem [100];
  logic [31:0] exp_rd [2];
  logic        last_win;
  logic [31:0] obs_rd [2];
  logic        obs_err [2];

  typedef struct {
    logic        id;
    logic        w_r;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 100; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    last_win  = 1'b1;
  endtask

  // Who wins given the set of requesters asking.
  function automatic logic pick(input logic [1:0] mask);
    if (mask == 2'b01) return 1'b0;
    if (mask == 2'b10) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return ~last_win;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ram(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d);
    chk({tag, " ram_addr"}, bus.ram_addr, a);
    chk({tag, " ram_w_r"}, {31'h0, bus.ram_w_r}, {31'h0, w});
    chk({tag, " ram_wr_data"}, bus.ram_wr_data, d);
  endtask

  task automatic chk_outputs(input string tag, input logic ack0, input logic ack1,
                             input logic err0, input logic err1);
    chk({tag, " m0_ack"}, {31'h0, bus.m0_ack}, {31'h0, ack0});
    chk({tag, " m1_ack"}, {31'h0, bus.m1_ack}, {31'h0, ack1});
    chk({tag, " m0_err"}, {31'h0, bus.m0_err}, {31'h0, err0});
    chk({tag, " m1_err"}, {31'h0, bus.m1_err}, {31'h0, err1});
    chk({tag, " m0_rd_data"}, bus.m0_rd_data, exp_rd[0]);
    chk({tag, " m1_rd_data"}, bus.m1_rd_data, exp_rd[1]);
  endtask

  // One transaction (one or two requesters), checked cycle by cycle.
  // Called with the arbiter idle; returns with it idle again.
  task automatic run_txn(input string tag, input logic [1:0] mask,
                         input logic wr0, input logic wr1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        w [2];
    logic        first;
    logic        second;
    logic        cur;
    logic        inr;
    logic        pend_err;
    logic [31:0] pend_rd;
    int          nsteps;
    int          ph;
    int          wr_cycles;
    int          exp_writes;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; w[0] = wr0; w[1] = wr1;
    bus.m0_req = mask[0]; bus.m0_w_r = wr0; bus.m0_addr = a0; bus.m0_wr_data = d0;
    bus.m1_req = mask[1]; bus.m1_w_r = wr1; bus.m1_addr = a1; bus.m1_wr_data = d1;
    first      = pick(mask);
    second     = ~first;
    nsteps     = (mask == 2'b11) ? 6 : 3;
    wr_cycles  = 0;
    exp_writes = 0;
    pend_err   = 1'b0;
    pend_rd    = 32'h0;
    for (int s = 1; s <= nsteps; s++) begin
      step();
      ph  = ((s - 1) % 3) + 1;
      cur = (s <= 3) ? first : second;
      if (!bus.ram_w_r) wr_cycles++;
      if (ph == 1) begin
        last_win = cur;
        inr = (a[cur] < 32'd100);
        if (inr) chk_ram({tag, " access"}, a[cur], w[cur], d[cur]);
        else     chk_ram({tag, " access"}, 32'h0, 1'b1, 32'h0);
        pend_err = ~inr;
        if (!inr)       pend_rd = 32'h0;
        else if (w[cur]) pend_rd = ref_mem[a[cur]];
        else            pend_rd = exp_rd[cur];
        if (inr && !w[cur]) begin
          ref_mem[a[cur]] = d[cur];
          exp_writes++;
        end
        chk_outputs({tag, " access"}, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (ph == 2) begin
        chk_ram({tag, " done"}, 32'h0, 1'b1, 32'h0);
        exp_rd[cur] = pend_rd;
        chk_outputs({tag, " done"}, cur == 1'b0, cur == 1'b1,
                    (cur == 1'b0) && pend_err, (cur == 1'b1) && pend_err);
        obs_rd[cur]  = cur ? bus.m1_rd_data : bus.m0_rd_data;
        obs_err[cur] = cur ? bus.m1_err : bus.m0_err;
        if (cur) bus.m1_req = 1'b0;
        else     bus.m0_req = 1'b0;
      end else begin
        chk_ram({tag, " idle"}, 32'h0, 1'b1, 32'h0);
        chk_outputs({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk({tag, " ram write cycles"}, 32'(wr_cycles), 32'(exp_writes));
    $display("[TB] %s mask=%b a0=%h a1=%h rd0=%h rd1=%h", tag, mask, a0, a1,
             bus.m0_rd_data, bus.m1_rd_data);
  endtask

  initial begin
    logic [1:0]  mask;
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        win;
    logic        oor;
    int          ph;
    int          acks1;
    logic [31:0] pend_rd;

    vecs[0] = '{1'b0, 1'b0, 32'd5,          32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd5,          32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd100,        32'h0,         1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h63,         32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h63,         32'h0,         1'b0, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b1, 32'h8000_0063,  32'h0,         1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'd7,          32'hA5A5_0007, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'd7,          32'h0,         1'b0, 32'hA5A5_0007};

    rst = 1'b1;
    bus.m0_req = 1'b0; bus.m0_w_r = 1'b1; bus.m0_addr = 32'h0; bus.m0_wr_data = 32'h0;
    bus.m1_req = 1'b0; bus.m1_w_r = 1'b1; bus.m1_addr = 32'h0; bus.m1_wr_data = 32'h0;
    model_reset();
    repeat (3) step();
    chk_ram("reset", 32'h0, 1'b1, 32'h0);
    chk_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Directed single-requester table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].id)
        run_txn($sformatf("vec%0d", i), 2'b10, 1'b1, vecs[i].w_r, 32'h0, vecs[i].addr, 32'h0, vecs[i].data);
      else
        run_txn($sformatf("vec%0d", i), 2'b01, vecs[i].w_r, 1'b1, vecs[i].addr, 32'h0, vecs[i].data, 32'h0);
      chk($sformatf("vec%0d err", i), {31'h0, obs_err[vecs[i].id]}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d rd_data", i), obs_rd[vecs[i].id], vecs[i].exp_rd);
    end

    // Randomized transactions, including ties.
    for (int t = 0; t < 40; t++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        oor = ($urandom_range(0, 7) == 0);
        if (oor) a[k] = ($urandom_range(0, 1) == 1) ? 32'd100 : ($urandom | 32'h8000_0000);
        else     a[k] = 32'($urandom_range(0, 99));
        w[k] = oor ? 1'b1 : 1'($urandom_range(0, 1));
        d[k] = $urandom;
      end
      run_txn($sformatf("rnd%0d", t), mask, w[0], w[1], a[0], a[1], d[0], d[1]);
    end

    // Both requesters read continuously: one ack every third cycle.
    bus.m0_req = 1'b1; bus.m0_w_r = 1'b1; bus.m0_addr = 32'd10;
    bus.m1_req = 1'b1; bus.m1_w_r = 1'b1; bus.m1_addr = 32'd20;
    win = 1'b0; pend_rd = 32'h0; acks1 = 0;
    for (int s = 1; s <= 17; s++) begin
      step();
      ph = ((s - 1) % 3) + 1;
      if (ph == 1) begin
        win = pick(2'b11);
        last_win = win;
        pend_rd = ref_mem[win ? 20 : 10];
        chk_outputs("cont access", 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (ph == 2) begin
        exp_rd[win] = pend_rd;
        if (win) acks1++;
        chk_outputs("cont done", win == 1'b0, win == 1'b1, 1'b0, 1'b0);
        $display("[TB] cont cycle %0d ack m%0d", s, win);
      end else begin
        chk_outputs("cont idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    chk("cont m1 acks", 32'(acks1), 32'd3);
`else
    chk("cont m1 acks", 32'(acks1), 32'd0);
`endif
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    step();
    chk_outputs("cont end", 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Reset during the ACCESS cycle of a write to address 7.
    bus.m0_req = 1'b1; bus.m0_w_r = 1'b0; bus.m0_addr = 32'd7; bus.m0_wr_data = 32'h7777_7777;
    step();
    chk_ram("abort access", 32'd7, 1'b0, 32'h7777_7777);
    rst = 1'b1;
    bus.m0_req = 1'b0;
    step();
    model_reset();
    chk_ram("abort after rst", 32'h0, 1'b1, 32'h0);
    chk_outputs("abort after rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_outputs("abort no ack", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_txn("post-abort read7", 2'b01, 1'b1, 1'b1, 32'd7, 32'h0, 32'h0, 32'h0);
    chk("post-abort rd7", obs_rd[0], 32'hC0DE_0007);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports m0_req and m1_req, input, 1 bit each: access request from requester 0 and requester 1.
REQ-004 SHALL have ports m0_w_r and m1_w_r, input, 1 bit each: access type, 0 = write, 1 = read.
REQ-005 SHALL have ports m0_addr and m1_addr, input, 32 bits each: word address.
REQ-006 SHALL have ports m0_wr_data and m1_wr_data, input, 32 bits each: write data.
REQ-007 SHALL have ports m0_ack and m1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-008 SHALL have ports m0_err and m1_err, output, 1 bit each: out-of-range flag, valid while the matching ack is high.
REQ-009 SHALL have ports m0_rd_data and m1_rd_data, output, 32 bits each: registered read data.
REQ-010 SHALL have port ram_addr, output, 32 bits: address to the RAM.
REQ-011 SHALL have port ram_w_r, output, 1 bit: RAM access type, 0 = write, 1 = read.
REQ-012 SHALL have port ram_wr_data, output, 32 bits: write data to the RAM.
REQ-013 SHALL have port ram_rd_data, input, 32 bits: read data from the RAM (combinational).

Function
REQ-014 SHALL implement an FSM with three states: IDLE, ACCESS and DONE.
REQ-015 In IDLE, with one or more requests high, SHALL latch the winner's id, w_r, addr and wr_data, then go to ACCESS.
REQ-016 In ACCESS, SHALL drive the latched request onto the ram_* ports for exactly one cycle, register ram_rd_data at the end of that cycle, then go to DONE.
REQ-017 In DONE, SHALL pulse the winner's ack for one cycle with rd_data valid, then go to IDLE.
REQ-018 SHALL complete every access with fixed latency: req sampled in cycle N, ram driven in cycle N+1, ack in cycle N+2.
REQ-019 Requester SHALL hold req, w_r, addr and wr_data stable until ack.
REQ-020 SHALL ignore req during DONE; a req still high in the following IDLE cycle is a new request.
REQ-021 Outside ACCESS, SHALL drive ram_addr = 0, ram_w_r = 1 and ram_wr_data = 0, so that no spurious write reaches the RAM.
REQ-022 Valid range SHALL be addr 0..99 (32'h63) inclusive, compared on the full 32 bits.
REQ-023 For an out-of-range addr: ACCESS keeps ram_w_r = 1, ram_addr = 0 and ram_wr_data = 0 (no RAM write); DONE asserts ack with err = 1 and rd_data = 0.
REQ-024 For a write: rd_data SHALL hold its previous value and err = 0.
REQ-025 The loser's ack SHALL stay low and its request SHALL stay pending until served.
REQ-026 The mN_rd_data output of the non-winning requester SHALL hold its value.
REQ-027 Both acks SHALL never be high in the same cycle.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE from any state, aborting any in-flight access with no ack.
REQ-029 rst SHALL clear m0_ack, m1_ack, m0_err and m1_err to 0.
REQ-030 rst SHALL clear m0_rd_data and m1_rd_data to 32'h0.
REQ-031 rst SHALL set ram_addr = 0, ram_w_r = 1 and ram_wr_data = 0.
REQ-032 rst SHALL set last_grant = 1, so requester 0 wins the first tie.
REQ-033 rst asserted during ACCESS SHALL cause ram_w_r to be 1 in the cycle after the reset edge.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on a simultaneous request, SHALL grant the requester other than last_grant, and update last_grant on every grant.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: SHALL use fixed priority, requester 0 always wins a tie; last_grant is unused.
REQ-036 A single request SHALL be granted immediately in either configuration.

Verification
REQ-037 Reset, then m0 writes addr 5, data 32'hDEADBEEF; later m0 reads addr 5 -> RAM sees w_r = 0 for exactly one cycle; second ack arrives 2 cycles after req with m0_rd_data = 32'hDEADBEEF and m0_err = 0.
REQ-038 m1 reads addr 100 -> ram_w_r stays 1 throughout; m1_ack with m1_err = 1 and m1_rd_data = 0.
REQ-039 m0 and m1 both request continuously, macro defined -> grants alternate 0, 1, 0, 1; each ack is 3 cycles after the previous one.
REQ-040 m0 and m1 both request continuously, macro undefined -> m0 always served; m1 is never acked while m0_req stays high.
REQ-041 rst pulsed during ACCESS of a write to addr 7 -> no ack is issued; ram_w_r = 1 in the cycle after the reset edge; all outputs read back at their reset values.
REQ-042 Request at addr 99 (32'h63) and at addr 32'h80000063 -> first completes with err = 0; second completes with err = 1.
